seg7_scan_ctrl: RTL and testbench



---
 rtl/seg7_scan_ctrl.sv | 150 +++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed common-anode 7-segment scanner with double-buffered digit memory,
// hex decode, brightness duty gating and digit mask. Define SEG7_BLINK_EN for per-digit blink.
module seg7_scan_ctrl #(
  parameter int NUM_DIGITS = 8,
  parameter int SCAN_DIV   = 200000,
  parameter int BLINK_DIV  = 64,
  localparam int ADDR_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [5:0]            wr_data,
  input  logic                  commit,
  input  logic [NUM_DIGITS-1:0] digit_mask,
  input  logic [2:0]            bright,
  output logic [NUM_DIGITS-1:0] led_en,
  output logic [6:0]            led_seg,
  output logic                  led_dp,
  output logic                  commit_pending,
  output logic                  frame_start
`ifdef SEG7_BLINK_EN
  ,
  input  logic [NUM_DIGITS-1:0] blink_mask
`endif
);

  localparam int SUB_LEN = SCAN_DIV / 8;
  localparam int SW      = (SUB_LEN > 1) ? $clog2(SUB_LEN) : 1;
  localparam logic [5:0] BLANK = 6'b100000;

  if (SCAN_DIV < 8 || (SCAN_DIV % 8) != 0) begin : g_bad_scan_div
    $error("SCAN_DIV must be a multiple of 8 and at least 8");
  end
  if (BLINK_DIV < 1) begin : g_bad_blink_div
    $error("BLINK_DIV must be at least 1");
  end

  // The slot tick is kept as (sub-phase, count within sub-phase) so no divider is needed.
  logic [SW-1:0]     sub_cnt_q;
  logic [2:0]        sub_q;
  logic [ADDR_W-1:0] idx_q;
  logic              commit_pending_q;
  logic [5:0]        shadow_q [NUM_DIGITS];
  logic [5:0]        active_q [NUM_DIGITS];

  logic [NUM_DIGITS-1:0] led_en_q, led_en_d;
  logic [6:0]            led_seg_q;
  logic                  led_dp_q;
  logic                  frame_start_q;

  logic       sub_wrap, slot_wrap, boundary, lit, blink_ok, do_copy;
  logic [5:0] cur_entry;

  function automatic logic [6:0] hex7(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
      4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
      4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
      4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
    endcase
    return s;
  endfunction

  always_comb begin
    sub_wrap  = (sub_cnt_q == SW'(SUB_LEN - 1));
    slot_wrap = sub_wrap && (sub_q == 3'd7);
    boundary  = slot_wrap && (idx_q == ADDR_W'(NUM_DIGITS - 1));
    do_copy   = boundary && commit_pending_q;
    cur_entry = active_q[idx_q];
    lit       = (sub_q <= bright) && digit_mask[idx_q] && !cur_entry[5] && blink_ok;
  end

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_en
    assign led_en_d[gi] = ~(lit && (idx_q == ADDR_W'(gi)));
  end

`ifdef SEG7_BLINK_EN
  localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  logic [FW-1:0] frame_cnt_q;
  logic          blink_off_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_q <= '0;
      blink_off_q <= 1'b0;
    end else if (boundary) begin
      if (frame_cnt_q == FW'(BLINK_DIV - 1)) begin
        frame_cnt_q <= '0;
        blink_off_q <= ~blink_off_q;
      end else begin
        frame_cnt_q <= frame_cnt_q + 1'b1;
      end
    end
  end

  assign blink_ok = !(blink_off_q && blink_mask[idx_q]);
`else
  assign blink_ok = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      sub_cnt_q        <= '0;
      sub_q            <= '0;
      idx_q            <= '0;
      commit_pending_q <= 1'b0;
      led_en_q         <= '1;
      led_seg_q        <= 7'h7F;
      led_dp_q         <= 1'b1;
      frame_start_q    <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        shadow_q[i] <= BLANK;
        active_q[i] <= BLANK;
      end
    end else begin
      sub_cnt_q <= sub_wrap ? '0 : sub_cnt_q + 1'b1;
      if (sub_wrap)
        sub_q <= sub_q + 1'b1;
      if (slot_wrap)
        idx_q <= boundary ? '0 : idx_q + 1'b1;

      if (do_copy)
        commit_pending_q <= 1'b0;
      else if (commit)
        commit_pending_q <= 1'b1;

      // Copy uses pre-write shadow contents; a same-cycle write lands in the next copy.
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (wr_en && (wr_addr == ADDR_W'(i)))
          shadow_q[i] <= wr_data;
        if (do_copy)
          active_q[i] <= shadow_q[i];
      end

      led_en_q      <= led_en_d;
      led_seg_q     <= lit ? hex7(cur_entry[3:0]) : 7'h7F;
      led_dp_q      <= lit ? ~cur_entry[4] : 1'b1;
      frame_start_q <= (idx_q == '0) && (sub_q == 3'd0) && (sub_cnt_q == '0);
    end
  end

  assign led_en         = led_en_q;
  assign led_seg        = led_seg_q;
  assign led_dp         = led_dp_q;
  assign commit_pending = commit_pending_q;
  assign frame_start    = frame_start_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with 4 digits, 16-cycle slots, 2-frame blink period.
// Pin position is tracked as a pin-cycle index within the 64-cycle frame.
module tb_seg7_scan_ctrl;

  localparam int ND = 4;
  localparam int SD = 16;
  localparam int BD = 2;
  localparam int FR = ND * SD;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [1:0] wr_addr = '0;
  logic [5:0] wr_data = '0;
  logic       commit = 1'b0;
  logic [3:0] digit_mask = 4'hF;
  logic [2:0] bright = 3'd7;
  logic [3:0] led_en;
  logic [6:0] led_seg;
  logic       led_dp, commit_pending, frame_start;
`ifdef SEG7_BLINK_EN
  logic [3:0] blink_mask = 4'h0;
`endif

  seg7_scan_ctrl #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .BLINK_DIV(BD)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .commit(commit), .digit_mask(digit_mask), .bright(bright),
    .led_en(led_en), .led_seg(led_seg), .led_dp(led_dp),
    .commit_pending(commit_pending), .frame_start(frame_start)
`ifdef SEG7_BLINK_EN
    , .blink_mask(blink_mask)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int pc = 0;
  int fr = 0;

  typedef struct {
    int         d;
    int         t;
    logic [2:0] br;
    logic [3:0] mask;
    logic [3:0] en;
    logic [6:0] seg;
    logic       dp;
  } vec_t;

  vec_t vecs[13];

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    pc = (pc + 1) % FR;
    if (pc == 0) fr++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (pin cycle %0d frame %0d)", name, act, exp, pc, fr);
    end
  endtask

  // Advance at least one cycle, until the pins show (digit d, tick t); bounded by one frame.
  task automatic goto(input int d, input int t);
    int tgt;
    tgt = d * SD + t;
    step();
    for (int i = 0; i < FR && pc != tgt; i++) step();
  endtask

  task automatic wr(input logic [1:0] a, input logic [5:0] v);
    wr_en = 1'b1; wr_addr = a; wr_data = v;
    step();
    wr_en = 1'b0;
    $display("write addr %0d data %02h", a, v);
  endtask

  task automatic count_lit(input string name, input int n, input int exp);
    int lit;
    int multi;
    lit = 0; multi = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (led_en != 4'hF) lit++;
      if ($countones(~led_en) > 1) multi++;
    end
    chk(name, lit, exp);
    chk({name, "_onehot"}, multi, 0);
    $display("%s: %0d lit cycles of %0d", name, lit, n);
  endtask

  initial begin
    vecs[0]  = '{d:0, t:0,  br:7, mask:4'hF, en:4'hE, seg:7'h79, dp:1'b1};
    vecs[1]  = '{d:0, t:15, br:7, mask:4'hF, en:4'hE, seg:7'h79, dp:1'b1};
    vecs[2]  = '{d:1, t:5,  br:7, mask:4'hF, en:4'hD, seg:7'h24, dp:1'b1};
    vecs[3]  = '{d:2, t:0,  br:7, mask:4'hF, en:4'hB, seg:7'h30, dp:1'b0};
    vecs[4]  = '{d:3, t:9,  br:7, mask:4'hF, en:4'h7, seg:7'h08, dp:1'b1};
    vecs[5]  = '{d:0, t:1,  br:0, mask:4'hF, en:4'hE, seg:7'h79, dp:1'b1};
    vecs[6]  = '{d:0, t:2,  br:0, mask:4'hF, en:4'hF, seg:7'h7F, dp:1'b1};
    vecs[7]  = '{d:1, t:7,  br:3, mask:4'hF, en:4'hD, seg:7'h24, dp:1'b1};
    vecs[8]  = '{d:1, t:8,  br:3, mask:4'hF, en:4'hF, seg:7'h7F, dp:1'b1};
    vecs[9]  = '{d:2, t:3,  br:7, mask:4'hB, en:4'hF, seg:7'h7F, dp:1'b1};
    vecs[10] = '{d:3, t:3,  br:7, mask:4'hB, en:4'h7, seg:7'h08, dp:1'b1};
    vecs[11] = '{d:0, t:14, br:6, mask:4'hF, en:4'hF, seg:7'h7F, dp:1'b1};
    vecs[12] = '{d:2, t:13, br:6, mask:4'hF, en:4'hB, seg:7'h30, dp:1'b0};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_en", led_en, 4'hF);
    chk("rst_seg", led_seg, 7'h7F);
    chk("rst_dp", led_dp, 1'b1);
    chk("rst_pend", commit_pending, 1'b0);
    chk("rst_fs", frame_start, 1'b0);
    rst = 1'b0;
    pc = FR - 1; fr = -1;
    step();
    chk("first_fs", frame_start, 1'b1);
    $display("reset released, first frame_start=%b", frame_start);

    // Idle frame: dark, exactly one frame_start at the next frame's first cycle
    begin
      int lit;
      int fsc;
      lit = 0; fsc = 0;
      for (int i = 0; i < FR; i++) begin
        step();
        if (led_en != 4'hF || led_seg != 7'h7F || led_dp != 1'b1) lit++;
        if (frame_start) fsc++;
      end
      chk("idle_lit", lit, 0);
      chk("idle_fs_count", fsc, 1);
      chk("idle_fs_at_0", frame_start, 1'b1);
      $display("idle frame: lit=%0d frame_starts=%0d", lit, fsc);
    end

    wr(2'd0, 6'h01);
    wr(2'd1, 6'h02);
    wr(2'd2, 6'h13);
    wr(2'd3, 6'h0A);
    commit = 1'b1;
    step();
    commit = 1'b0;
    chk("commit_set", commit_pending, 1'b1);
    goto(3, 14);
    chk("pend_before_bnd", commit_pending, 1'b1);
    chk("still_blank", led_en, 4'hF);
    goto(3, 15);
    chk("pend_cleared", commit_pending, 1'b0);

    for (int i = 0; i < 13; i++) begin
      bright = vecs[i].br;
      digit_mask = vecs[i].mask;
      goto(vecs[i].d, vecs[i].t);
      chk($sformatf("v%0d_en", i), led_en, vecs[i].en);
      chk($sformatf("v%0d_seg", i), led_seg, vecs[i].seg);
      chk($sformatf("v%0d_dp", i), led_dp, vecs[i].dp);
      chk($sformatf("v%0d_fs", i), frame_start, (vecs[i].d == 0 && vecs[i].t == 0));
      $display("vec %0d: digit %0d tick %0d bright %0d mask %h -> en=%h seg=%h dp=%b fs=%b",
               i, vecs[i].d, vecs[i].t, vecs[i].br, vecs[i].mask, led_en, led_seg, led_dp, frame_start);
    end

    // Duty per slot
    digit_mask = 4'hF;
    bright = 3'd0; goto(0, 15); count_lit("duty_b0", SD, 2);
    bright = 3'd3; goto(0, 15); count_lit("duty_b3", SD, 8);
    bright = 3'd7; goto(0, 15); count_lit("duty_b7", SD, 16);

    // Shadow write without commit leaves the display alone
    wr(2'd1, 6'h05);
    for (int f = 0; f < 3; f++) begin
      goto(1, 4);
      chk("no_commit_seg", led_seg, 7'h24);
      $display("frame %0d digit1 seg=%h pending=%b", fr, led_seg, commit_pending);
    end
    goto(1, 8);
    commit = 1'b1;
    step();
    commit = 1'b0;
    chk("mid_commit_pend", commit_pending, 1'b1);
    goto(3, 14);
    chk("mid_pend_hold", commit_pending, 1'b1);
    chk("mid_old_d3", led_seg, 7'h08);
    goto(3, 15);
    chk("mid_pend_clr", commit_pending, 1'b0);
    goto(1, 0);
    chk("new_5_seg", led_seg, 7'h12);
    chk("new_5_en", led_en, 4'hD);
    $display("after commit digit1 seg=%h", led_seg);

    // Write and commit in the same cycle: the write is part of the copy
    goto(2, 0);
    wr_en = 1'b1; wr_addr = 2'd0; wr_data = 6'h08; commit = 1'b1;
    step();
    wr_en = 1'b0; commit = 1'b0;
    goto(0, 0);
    chk("wc_same_seg", led_seg, 7'h00);
    chk("wc_same_pend", commit_pending, 1'b0);
    $display("write+commit same cycle: digit0 seg=%h", led_seg);

    // Commit landing on the boundary cycle waits for the following boundary
    goto(3, 14);
    commit = 1'b1;
    step();
    commit = 1'b0;
    chk("bnd_commit_pend", commit_pending, 1'b1);
    wr(2'd2, 6'h07);
    goto(2, 0);
    chk("bnd_not_copied_seg", led_seg, 7'h30);
    chk("bnd_not_copied_dp", led_dp, 1'b0);
    goto(3, 15);
    chk("bnd_pend_clr", commit_pending, 1'b0);
    goto(2, 0);
    chk("bnd_copied_seg", led_seg, 7'h78);
    chk("bnd_copied_dp", led_dp, 1'b1);
    $display("boundary commit: digit2 seg=%h dp=%b", led_seg, led_dp);

`ifdef SEG7_BLINK_EN
    blink_mask = 4'h1;
    for (int f = 0; f < 4; f++) begin
      goto(0, 0);
      chk("blink_d0", led_en, (((fr / 2) % 2) == 0) ? 4'hE : 4'hF);
      goto(1, 0);
      chk("blink_d1", led_en, 4'hD);
      $display("blink frame %0d: digit1 en=%h", fr, led_en);
    end
    blink_mask = 4'h0;
`endif

    // Reset mid-frame with a commit pending
    goto(2, 5);
    wr(2'd0, 6'h03);
    commit = 1'b1;
    step();
    commit = 1'b0;
    chk("pre_rst_pend", commit_pending, 1'b1);
    rst = 1'b1;
    step();
    chk("mid_rst_en", led_en, 4'hF);
    chk("mid_rst_pend", commit_pending, 1'b0);
    chk("mid_rst_fs", frame_start, 1'b0);
    rst = 1'b0;
    pc = FR - 1; fr = -1;
    step();
    chk("post_rst_fs", frame_start, 1'b1);
    count_lit("post_rst_dark", 2 * FR, 0);
    chk("post_rst_pend", commit_pending, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
